fpu_addsub_seq: RTL and testbench

- Parametrised, multi-cycle floating-point adder/subtractor. Successor to the fixed-format FPU datapath.
- Operand format is {sign, exponent[EXP_W], mantissa[MAN_W]}, with a hidden leading 1 and a biased exponent.
- Adds a start/done handshake, a runtime add/subtract mode, an iterative align/normalise FSM and a priority status vector.
- Sits between the operand registers and the result/status display logic.

---
 rtl/fpu_addsub_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_fpu_addsub_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor with start/done handshake and one-hot status.
// Optional macro FPU_ROUND_NEAREST_EN: round-to-nearest-even in a two-cycle PACK (default truncates).
module fpu_addsub_seq #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25,
    parameter int BIAS  = 2**(EXP_W-1)-1
) (
    input  logic                 clock100KHz,
    input  logic                 reset,
    input  logic                 start_in,
    input  logic                 op_sub_in,
    input  logic [EXP_W+MAN_W:0] op_A_in,
    input  logic [EXP_W+MAN_W:0] op_B_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [EXP_W+MAN_W:0] data_out,
    output logic [3:0]           status_out
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XM = MAN_W + 4;
    localparam int XW = EXP_W + 2;

    // Exponents are carried unbiased and signed so the limits below read as real magnitudes.
    localparam logic signed [XW-1:0] BIAS_X  = XW'(BIAS);
    localparam logic signed [XW-1:0] EXP_MIN = XW'(1 - BIAS);
    localparam logic signed [XW-1:0] EXP_MAX = XW'(2**EXP_W - 1 - BIAS);
    localparam logic signed [XW-1:0] EXP_INC = XW'(1);
    localparam logic [7:0]           SHIFT_MAX = 8'(MAN_W + 2);

    localparam logic [3:0] ST_EXACT = 4'b0001;
    localparam logic [3:0] ST_OVF   = 4'b0010;
    localparam logic [3:0] ST_UNF   = 4'b0100;
    localparam logic [3:0] ST_INX   = 4'b1000;

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, PACK, PACK_OUT, DONE} state_t;

    state_t                 state_reg;
    logic [W-1:0]           a_reg;
    logic [W-1:0]           b_reg;
    logic                   sign_reg;
    logic                   eff_sub_reg;
    logic signed [XW-1:0]   exp_a_reg;
    logic signed [XW-1:0]   exp_b_reg;
    logic [XM-1:0]          man_a_reg;
    logic [XM-1:0]          man_b_reg;
    logic [XM:0]            sum_reg;
    logic [7:0]             shift_cnt_reg;
    logic                   uflow_reg;
    logic [W-1:0]           result_reg;
    logic [3:0]             stat_reg;

    logic                   a_zero;
    logic                   b_zero;
    logic                   a_ge_b;
    logic signed [XW-1:0]   a_exp_unb;
    logic signed [XW-1:0]   b_exp_unb;
    logic [XM:0]            add_res;
    logic [W-1:0]           pack_data;
    logic [3:0]             pack_stat;

    always_comb begin
        a_zero    = (a_reg[W-2:MAN_W] == '0);
        b_zero    = (b_reg[W-2:MAN_W] == '0);
        a_ge_b    = (a_reg[W-2:0] >= b_reg[W-2:0]);
        a_exp_unb = $signed({2'b00, a_reg[W-2:MAN_W]}) - BIAS_X;
        b_exp_unb = $signed({2'b00, b_reg[W-2:MAN_W]}) - BIAS_X;
        add_res   = eff_sub_reg ? ({1'b0, man_a_reg} - {1'b0, man_b_reg})
                                : ({1'b0, man_a_reg} + {1'b0, man_b_reg});
    end

    // sum_reg layout: [XM] carry, [XM-1] hidden, [XM-2:3] mantissa, [2:0] guard/round/sticky.
    always_comb begin
        pack_data = {sign_reg, EXP_W'(exp_a_reg + BIAS_X), sum_reg[XM-2:3]};
        pack_stat = (|sum_reg[2:0]) ? ST_INX : ST_EXACT;
        if (exp_a_reg > EXP_MAX) begin
            pack_data = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
            pack_stat = ST_OVF;
        end else if (uflow_reg) begin
            pack_data = {sign_reg, {(W-1){1'b0}}};
            pack_stat = ST_UNF;
        end
    end

`ifdef FPU_ROUND_NEAREST_EN
    logic [MAN_W+1:0] rnd_man;
    logic             rnd_up;

    always_comb begin
        rnd_man = {1'b0, sum_reg[XM-1:3]} + {{(MAN_W+1){1'b0}}, 1'b1};
        rnd_up  = sum_reg[2] & (sum_reg[3] | sum_reg[1] | sum_reg[0]);
    end
`endif

    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            state_reg     <= IDLE;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            data_out      <= '0;
            status_out    <= ST_EXACT;
            a_reg         <= '0;
            b_reg         <= '0;
            sign_reg      <= 1'b0;
            eff_sub_reg   <= 1'b0;
            exp_a_reg     <= '0;
            exp_b_reg     <= '0;
            man_a_reg     <= '0;
            man_b_reg     <= '0;
            sum_reg       <= '0;
            shift_cnt_reg <= '0;
            uflow_reg     <= 1'b0;
            result_reg    <= '0;
            stat_reg      <= ST_EXACT;
        end else begin
            done_out <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_in) begin
                        a_reg     <= op_A_in;
                        b_reg     <= {op_B_in[W-1] ^ op_sub_in, op_B_in[W-2:0]};
                        busy_out  <= 1'b1;
                        state_reg <= UNPACK;
                    end
                end
                UNPACK: begin
                    shift_cnt_reg <= '0;
                    uflow_reg     <= 1'b0;
                    eff_sub_reg   <= a_reg[W-1] ^ b_reg[W-1];
                    if (a_zero && b_zero) begin
                        result_reg <= '0;
                        stat_reg   <= ST_EXACT;
                        state_reg  <= DONE;
                    end else if (a_zero) begin
                        result_reg <= b_reg;
                        stat_reg   <= ST_EXACT;
                        state_reg  <= DONE;
                    end else if (b_zero) begin
                        result_reg <= a_reg;
                        stat_reg   <= ST_EXACT;
                        state_reg  <= DONE;
                    end else if (a_ge_b) begin
                        sign_reg  <= a_reg[W-1];
                        exp_a_reg <= a_exp_unb;
                        exp_b_reg <= b_exp_unb;
                        man_a_reg <= {1'b1, a_reg[MAN_W-1:0], 3'b000};
                        man_b_reg <= {1'b1, b_reg[MAN_W-1:0], 3'b000};
                        state_reg <= ALIGN;
                    end else begin
                        sign_reg  <= b_reg[W-1];
                        exp_a_reg <= b_exp_unb;
                        exp_b_reg <= a_exp_unb;
                        man_a_reg <= {1'b1, b_reg[MAN_W-1:0], 3'b000};
                        man_b_reg <= {1'b1, a_reg[MAN_W-1:0], 3'b000};
                        state_reg <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (exp_b_reg == exp_a_reg) begin
                        state_reg <= ADD;
                    end else if (shift_cnt_reg > SHIFT_MAX) begin
                        man_b_reg <= {{(XM-1){1'b0}}, |man_b_reg};
                        state_reg <= ADD;
                    end else begin
                        man_b_reg     <= {1'b0, man_b_reg[XM-1:2], man_b_reg[1] | man_b_reg[0]};
                        exp_b_reg     <= exp_b_reg + EXP_INC;
                        shift_cnt_reg <= shift_cnt_reg + 8'd1;
                    end
                end
                ADD: begin
                    if (add_res == '0) begin
                        result_reg <= '0;
                        stat_reg   <= ST_EXACT;
                        state_reg  <= DONE;
                    end else begin
                        sum_reg   <= add_res;
                        state_reg <= NORM;
                    end
                end
                NORM: begin
                    if (sum_reg[XM]) begin
                        sum_reg   <= {1'b0, sum_reg[XM:2], sum_reg[1] | sum_reg[0]};
                        exp_a_reg <= exp_a_reg + EXP_INC;
                        state_reg <= PACK;
                    end else if (sum_reg[XM-1]) begin
                        state_reg <= PACK;
                    end else if (exp_a_reg == EXP_MIN) begin
                        uflow_reg <= 1'b1;
                        state_reg <= PACK;
                    end else begin
                        sum_reg   <= {sum_reg[XM-1:0], 1'b0};
                        exp_a_reg <= exp_a_reg - EXP_INC;
                    end
                end
`ifdef FPU_ROUND_NEAREST_EN
                PACK: begin
                    // A rounding carry out of the hidden bit renormalises to 1.000... at exponent+1.
                    if (!uflow_reg && rnd_up) begin
                        if (rnd_man[MAN_W+1]) begin
                            sum_reg   <= {1'b0, rnd_man[MAN_W+1:1], sum_reg[2:0]};
                            exp_a_reg <= exp_a_reg + EXP_INC;
                        end else begin
                            sum_reg <= {1'b0, rnd_man[MAN_W:0], sum_reg[2:0]};
                        end
                    end
                    state_reg <= PACK_OUT;
                end
                PACK_OUT: begin
                    result_reg <= pack_data;
                    stat_reg   <= pack_stat;
                    state_reg  <= DONE;
                end
`else
                PACK: begin
                    result_reg <= pack_data;
                    stat_reg   <= pack_stat;
                    state_reg  <= DONE;
                end
`endif
                DONE: begin
                    data_out   <= result_reg;
                    status_out <= stat_reg;
                    done_out   <= 1'b1;
                    busy_out   <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Scoreboard bench for fpu_addsub_seq: expected results queued at start, checked on done_out.
`timescale 1ns/1ps
module tb_fpu_addsub_seq;
    localparam int EXP_W = 6;
    localparam int MAN_W = 25;
    localparam int W     = 1 + EXP_W + MAN_W;

    localparam logic [3:0] ST_EXACT = 4'b0001;
    localparam logic [3:0] ST_OVF   = 4'b0010;
    localparam logic [3:0] ST_UNF   = 4'b0100;
    localparam logic [3:0] ST_INX   = 4'b1000;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_in;
    logic         op_sub_in;
    logic [W-1:0] op_A_in;
    logic [W-1:0] op_B_in;
    logic         busy_out;
    logic         done_out;
    logic [W-1:0] data_out;
    logic [3:0]   status_out;

    int           vec_cnt  = 0;
    int           err_cnt  = 0;
    int           done_cnt = 0;
    logic         prev_done = 1'b0;
    logic [W+3:0] sb_q[$];
    logic [W+3:0] exp_e;

    always #5 clk = ~clk;

    fpu_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clock100KHz (clk),
        .reset       (reset),
        .start_in    (start_in),
        .op_sub_in   (op_sub_in),
        .op_A_in     (op_A_in),
        .op_B_in     (op_B_in),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .data_out    (data_out),
        .status_out  (status_out)
    );

    function automatic logic [W-1:0] mk(input logic s, input int e, input logic [MAN_W-1:0] m);
        return {s, e[EXP_W-1:0], m};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Result monitor: one line per completed operation.
    always @(negedge clk) begin
        if (reset && done_out) begin
            done_cnt++;
            check("done_width", 64'(prev_done), 64'(0));
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(1), 64'(0));
            end else begin
                exp_e = sb_q.pop_front();
                check("data", 64'(data_out), 64'(exp_e[W+3:4]));
                check("status", 64'(status_out), 64'(exp_e[3:0]));
                $display("op %0d: data=%h status=%b (want %h %b)",
                         done_cnt, data_out, status_out, exp_e[W+3:4], exp_e[3:0]);
            end
        end
        prev_done <= done_out;
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] exp_d, input logic [3:0] exp_s, input int noise);
        int cyc;
        op_A_in   = a;
        op_B_in   = b;
        op_sub_in = sub;
        start_in  = 1'b1;
        sb_q.push_back({exp_d, exp_s});
        @(negedge clk);
        check("busy", 64'(busy_out), 64'(1));
        cyc = 1;
        if (noise > 0) begin
            op_A_in   = mk(1'b1, 7, 25'h1ABCDE);
            op_B_in   = mk(1'b0, 9, 25'h012345);
            op_sub_in = ~sub;
            repeat (noise) @(negedge clk);
            cyc = cyc + noise;
        end
        start_in = 1'b0;
        while (!done_out && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!done_out) begin
            check("timeout", 64'(0), 64'(1));
            sb_q.delete();
        end else begin
            check("latency", 64'(cyc <= 61), 64'(1));
        end
    endtask

    initial begin
        int d0;
        reset     = 1'b0;
        start_in  = 1'b0;
        op_sub_in = 1'b0;
        op_A_in   = '0;
        op_B_in   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_out), 64'(0));
        check("rst_done", 64'(done_out), 64'(0));
        check("rst_data", 64'(data_out), 64'(0));
        check("rst_status", 64'(status_out), 64'(ST_EXACT));
        reset = 1'b1;
        @(negedge clk);

        run_op(mk(0,31,0),          mk(0,31,0),  1'b0, mk(0,32,0),          ST_EXACT, 0);
        run_op(mk(0,31,0),          mk(0,31,0),  1'b1, '0,                  ST_EXACT, 0);
        run_op(mk(0,31,25'h0FFFFFF), mk(0,31,1), 1'b0, mk(0,32,25'h0800000), ST_EXACT, 0);
        run_op(mk(0,63,'1),         mk(0,63,'1), 1'b0, mk(0,63,'1),         ST_OVF,   0);
        run_op(mk(0,50,100),        mk(0,10,100), 1'b0, mk(0,50,100),       ST_INX,   0);
        run_op(mk(0,1,1),           mk(1,1,0),   1'b0, '0,                  ST_UNF,   0);
        run_op(mk(1,32,0),          mk(1,32,0),  1'b0, mk(1,33,0),          ST_EXACT, 0);
        run_op(mk(0,31,0),          mk(0,30,0),  1'b0, mk(0,31,25'h1000000), ST_EXACT, 0);
        run_op(mk(0,30,0),          mk(0,31,0),  1'b1, mk(1,30,0),          ST_EXACT, 0);
        run_op(mk(1,40,25'h123),    mk(0,0,5),   1'b1, mk(1,40,25'h123),    ST_EXACT, 0);
        run_op(mk(0,0,7),           mk(0,20,3),  1'b1, mk(1,20,3),          ST_EXACT, 0);
        run_op(mk(1,0,0),           mk(1,0,0),   1'b0, '0,                  ST_EXACT, 0);
        run_op(mk(0,31,0),          mk(0,5,0),   1'b0, mk(0,31,0),          ST_INX,   0);

        // Abort a long operation while it is aligning.
        op_A_in   = mk(0,50,100);
        op_B_in   = mk(0,10,100);
        op_sub_in = 1'b0;
        start_in  = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy_out), 64'(0));
        check("abort_done", 64'(done_out), 64'(0));
        check("abort_data", 64'(data_out), 64'(0));
        check("abort_status", 64'(status_out), 64'(ST_EXACT));
        reset = 1'b1;
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'(0));

        // Restart after abort; start_in held during busy must be ignored.
        run_op(mk(0,50,100), mk(0,10,100), 1'b0, mk(0,50,100), ST_INX, 3);
        run_op(mk(0,31,0),   mk(0,31,0),   1'b0, mk(0,32,0),   ST_EXACT, 0);
        repeat (5) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, observed hang expected finish");
        $fatal(1);
    end
endmodule
